// File: rtl/rdc_multimode.sv
// Request duration counter: per-channel pulse-width/accumulate counters, sticky IRQs, watermarks, first offender.
// Latency: count after each edge, IRQ one edge later; no backpressure. Option RDC_VIOLATION_CNT_EN adds violation_cnt_o.
module rdc_multimode #(
  parameter int WEIGHTS_WIDTH = 8,
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 2,
  localparam int N_COUNTERS   = N_CORES * CORE_EVENTS,
  localparam int IDX_W        = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [N_COUNTERS-1:0]               events_i,
  input  logic [N_COUNTERS*WEIGHTS_WIDTH-1:0] weights_i,
  input  logic [N_COUNTERS-1:0]               mode_i,
  input  logic [N_COUNTERS-1:0]               event_mask_i,
  input  logic [N_COUNTERS-1:0]               irq_clear_i,
  input  logic                                wm_clear_i,
  output logic                                interruption_rdc_o,
  output logic [N_COUNTERS-1:0]               interruption_vector_rdc_o,
  output logic [N_COUNTERS*WEIGHTS_WIDTH-1:0] watermark_o,
  output logic                                first_valid_o,
  output logic [IDX_W-1:0]                    first_idx_o
`ifdef RDC_VIOLATION_CNT_EN
  ,
  output logic [N_COUNTERS*8-1:0]             violation_cnt_o
`endif
);

  logic [N_COUNTERS-1:0][WEIGHTS_WIDTH-1:0] wt;
  logic [N_COUNTERS-1:0][WEIGHTS_WIDTH-1:0] cnt_q;
  logic [N_COUNTERS-1:0][WEIGHTS_WIDTH-1:0] wm_q;
  logic [N_COUNTERS-1:0]                    vec_q;
  logic [N_COUNTERS-1:0]                    hit;
  logic [N_COUNTERS-1:0]                    new_hit;
  logic                                     first_vld_q;
  logic [IDX_W-1:0]                         first_idx_q;
  logic [IDX_W-1:0]                         low_idx;

  assign wt = weights_i;

  always_comb begin
    hit     = '0;
    low_idx = '0;
    for (int k = 0; k < N_COUNTERS; k++) begin
      hit[k] = event_mask_i[k] & enable_i & (wt[k] != '0) & (cnt_q[k] >= wt[k]);
    end
    new_hit = hit & ~vec_q;
    // Scan downward so the lowest offending channel wins.
    for (int k = N_COUNTERS - 1; k >= 0; k--) begin
      if (new_hit[k]) low_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_COUNTERS; k++) begin
        if (!enable_i || !event_mask_i[k]) begin
          cnt_q[k] <= '0;
        end else if (mode_i[k] && irq_clear_i[k]) begin
          cnt_q[k] <= '0;
        end else if (events_i[k]) begin
          if (cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + WEIGHTS_WIDTH'(1);
        end else if (!mode_i[k]) begin
          cnt_q[k] <= '0;
        end
      end
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          vec_q <= '0;
    else if (!enable_i) vec_q <= '0;
    else                vec_q <= (vec_q & ~irq_clear_i) | hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wm_q <= '0;
    end else begin
      for (int k = 0; k < N_COUNTERS; k++) begin
        if (wm_clear_i)                         wm_q[k] <= '0;
        else if (enable_i && cnt_q[k] > wm_q[k]) wm_q[k] <= cnt_q[k];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else if (!enable_i) begin
      first_vld_q <= 1'b0;
    end else if (!first_vld_q) begin
      if (|new_hit) begin
        first_vld_q <= 1'b1;
        first_idx_q <= low_idx;
      end
    end else if (irq_clear_i[first_idx_q] && !hit[first_idx_q]) begin
      first_vld_q <= 1'b0;
    end
  end

`ifdef RDC_VIOLATION_CNT_EN
  logic [N_COUNTERS-1:0]       hit_q;
  logic [N_COUNTERS-1:0][7:0]  vcnt_q;

  // hit is forced low while disabled, so counts naturally hold then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q  <= '0;
      vcnt_q <= '0;
    end else begin
      hit_q <= hit;
      for (int k = 0; k < N_COUNTERS; k++) begin
        if (wm_clear_i)                                   vcnt_q[k] <= '0;
        else if (hit[k] && !hit_q[k] && vcnt_q[k] != '1) vcnt_q[k] <= vcnt_q[k] + 8'd1;
      end
    end
  end

  assign violation_cnt_o = vcnt_q;
`endif

  assign interruption_vector_rdc_o = vec_q;
  assign interruption_rdc_o        = |vec_q;
  assign watermark_o               = wm_q;
  assign first_valid_o             = first_vld_q;
  assign first_idx_o               = first_idx_q;

endmodule

// File: doc/rdc_multimode.md
Name: rdc_multimode

Overview:
- Successor Request Duration Counter for the PMU/MCCU contention-monitoring subsystem.
- Tracks per-event request duration for N_CORES x CORE_EVENTS monitored signals, in one of two per-event modes: consecutive pulse width or accumulated high time.
- Raises sticky, individually clearable interrupts when a count reaches its weight.
- Keeps clearable high watermarks and captures the first offending event. Sits beside the MCCU and is programmed by the PMU register bank.

Parameters:
- WEIGHTS_WIDTH, 8, width of counters, weights and watermarks.
- N_CORES, 4, number of monitored cores.
- CORE_EVENTS, 2, events per core.
- N_COUNTERS, N_CORES*CORE_EVENTS (localparam), total channels. Channel k = core*CORE_EVENTS + event.
- IDX_W, max(1,$clog2(N_COUNTERS)) (localparam), width of the offender index.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  block enable.
- events_i  in  N_COUNTERS  monitored event levels, bit k = channel k.
- weights_i  in  N_COUNTERS*WEIGHTS_WIDTH  per-channel quota; slice k = [k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]; 0 disables the channel interrupt.
- mode_i  in  N_COUNTERS  0 = consecutive duration, 1 = accumulate.
- event_mask_i  in  N_COUNTERS  1 = channel monitored.
- irq_clear_i  in  N_COUNTERS  single-cycle write-1-to-clear of sticky vector bits.
- wm_clear_i  in  1  pulse, clears all watermarks.
- interruption_rdc_o  out  1  OR of the sticky interrupt vector.
- interruption_vector_rdc_o  out  N_COUNTERS  sticky per-channel interrupt.
- watermark_o  out  N_COUNTERS*WEIGHTS_WIDTH  per-channel high watermark, same slicing as weights_i.
- first_valid_o  out  1  first-offender capture valid.
- first_idx_o  out  IDX_W  channel index of the first offender.

Behaviour:
- Reset (rst_i=1, async): all counters, vector, watermarks, first_valid_o and first_idx_o = 0; interruption_rdc_o = 0.
- Counter k, evaluated in priority order:
  - enable_i=0 or event_mask_i[k]=0 -> 0.
  - mode 1 and irq_clear_i[k]=1 -> 0.
  - events_i[k]=1 -> +1, saturating at all-ones (never wraps).
  - events_i[k]=0: mode 0 -> 0; mode 1 -> hold.
- Changing mode_i while enabled takes effect on the next edge with no implicit clear.
- hit[k] (combinational) = event_mask_i[k] & enable_i & (weight_k != 0) & (count_k >= weight_k).
- Vector bit k on each edge:
  - enable_i=0 -> 0.
  - Otherwise the next value is (vec[k] & ~irq_clear_i[k]) | hit[k]; set wins over a simultaneous clear.
- interruption_rdc_o = |interruption_vector_rdc_o (registered source, no combinational path from events_i).
- Latency: an event high for W consecutive sampled edges gives count=W after edge W; the vector bit and IRQ assert after edge W+1.
- Watermark k:
  - wm_clear_i=1 -> 0 (clear wins over update).
  - Else enable_i=1 and count_k > wm_k -> count_k.
  - Else hold. Watermarks hold while disabled.
- First offender:
  - Capture when first_valid_o=0 and any channel has hit[k] & ~vec[k]: set first_valid_o and first_idx_o = lowest such k.
  - Capture is frozen while valid.
  - first_valid_o clears when irq_clear_i[first_idx_o]=1 with no simultaneous re-hit on that channel, or when enable_i=0. first_idx_o holds its last value.
- enable_i low mid-operation: counters, vector and first_valid_o cleared on the next edge; watermarks retained.
- Weight = all-ones: reachable by a saturated counter (>= comparison), so it does trigger.

Optional Feature:
- Macro: RDC_VIOLATION_CNT_EN.
- Defined:
  - Adds output violation_cnt_o, N_COUNTERS*8 bits.
  - Per-channel 8-bit saturating count of rising edges of hit[k].
  - Cleared by reset or wm_clear_i; held while disabled.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Mode 0, weight 5, event channel 0 high 5 cycles then low -> vector bit0 and IRQ high after edge 6; counter returns to 0; watermark 5; first_idx_o=0, first_valid_o=1.
- Mode 0, event high 4 cycles, low 1, high 4 -> no interrupt; watermark 4.
- Mode 1, same stimulus with weight 6 -> accumulated count 6, IRQ asserts; irq_clear_i[0] pulse -> counter 0; vector cleared unless the event is still at weight.
- Channels 3 and 1 cross their weights on the same edge -> first_idx_o=1; clear bit 3 only -> first_valid_o stays 1; clear bit 1 -> first_valid_o=0.
- Weight 255, event held for 300 cycles -> count saturates at 255 with no wrap, IRQ asserts; weight 0 -> never asserts; mask 0 -> count stays 0.
- Assert rst_i mid-count, deassert asynchronously -> all outputs 0 immediately; wm_clear_i concurrent with a new maximum -> watermark 0.
